// File: rtl/video_timing_gen.sv
// Pixel-clock raster timing generator: x/y counters plus {hsync,vsync,de} and
// line/frame strobes, delayed PIPE_DLY cycles to line up with the pixel pipeline.
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int PIPE_DLY = 2,
  parameter int COORD_W  = 14
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_enable,
  output logic [COORD_W-1:0] o_x,
  output logic [COORD_W-1:0] o_y,
  output logic [2:0]         o_hvesync,
  output logic               o_line_start,
  output logic               o_frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [COORD_W-1:0] H_ACT_C  = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_ACT_C  = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);

  // Word layout throughout: {hsync, vsync, de, line_start, frame_start}.
  localparam logic [4:0] INACTIVE = {~H_POL, ~V_POL, 3'b000};

  logic [COORD_W-1:0] x_q, y_q;
  logic [COORD_W-1:0] x_nxt, y_nxt;
  logic               run_q;
  logic [4:0]         out_w;

  function automatic logic [4:0] decode(input logic [COORD_W-1:0] x,
                                        input logic [COORD_W-1:0] y,
                                        input logic               run);
    logic hs, vs, de, ls, fs;
    de = (x < H_ACT_C) && (y < V_ACT_C);
    hs = (x >= HS_START && x < HS_END) ? H_POL : ~H_POL;
    vs = (y >= VS_START && y < VS_END) ? V_POL : ~V_POL;
    ls = (x == '0);
    fs = (x == '0) && (y == '0);
    return run ? {hs, vs, de, ls, fs} : INACTIVE;
  endfunction

  // run_q marks that the pixel on x_q/y_q belongs to a running raster. When the
  // raster restarts, (0,0) is held for one cycle so its frame strobe is emitted.
  always_comb begin
    x_nxt = x_q;
    y_nxt = y_q;
    if (!i_enable || !run_q) begin
      x_nxt = '0;
      y_nxt = '0;
    end else if (x_q == H_LAST) begin
      x_nxt = '0;
      y_nxt = (y_q == V_LAST) ? '0 : y_q + COORD_W'(1);
    end else begin
      x_nxt = x_q + COORD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q   <= '0;
      y_q   <= '0;
      run_q <= i_enable;
    end else begin
      x_q   <= x_nxt;
      y_q   <= y_nxt;
      run_q <= i_enable;
    end
  end

  generate
    if (PIPE_DLY == 0) begin : g_aligned
      // Decode the upcoming pixel so the registered word lines up with o_x/o_y.
      logic [4:0] out_q;
      always_ff @(posedge clk) begin
        if (reset) out_q <= INACTIVE;
        else       out_q <= decode(x_nxt, y_nxt, i_enable);
      end
      assign out_w = out_q;
    end else begin : g_delayed
      logic [4:0] raw_cur;
      logic [4:0] pipe [PIPE_DLY];
      assign raw_cur = decode(x_q, y_q, run_q);
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < PIPE_DLY; i++) pipe[i] <= INACTIVE;
        end else begin
          pipe[0] <= raw_cur;
          for (int i = 1; i < PIPE_DLY; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign out_w = pipe[PIPE_DLY-1];
    end
  endgenerate

  assign o_x           = x_q;
  assign o_y           = y_q;
  assign o_hvesync     = out_w[4:2];
  assign o_line_start  = out_w[1];
  assign o_frame_start = out_w[0];

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: three small-raster instances (delays 2, 0, 3; both
// sync polarities) checked every cycle against a pixel-index reference model.
module tb_video_timing_gen;

  localparam int N = 3;
  localparam int HA[N] = '{16, 10, 12};
  localparam int HF[N] = '{2, 1, 2};
  localparam int HS[N] = '{3, 2, 2};
  localparam int HB[N] = '{4, 3, 2};
  localparam int VA[N] = '{6, 4, 5};
  localparam int VF[N] = '{1, 1, 1};
  localparam int VS[N] = '{2, 1, 1};
  localparam int VB[N] = '{2, 2, 1};
  localparam bit HP[N] = '{1'b0, 1'b1, 1'b0};
  localparam bit VP[N] = '{1'b0, 1'b1, 1'b0};
  localparam int DL[N] = '{2, 0, 3};

  logic        clk;
  logic        reset;
  logic        i_enable;
  logic [13:0] ox [N];
  logic [13:0] oy [N];
  logic [2:0]  hv [N];
  logic        ls [N];
  logic        fs [N];

  int n_vec = 0;
  int n_err = 0;

  // Reference state: linear pixel index within the frame and a history of raw words.
  int         t   [N];
  bit         running [N];
  logic [4:0] hist [N][16];

  for (genvar g = 0; g < N; g++) begin : g_dut
    video_timing_gen #(
      .H_ACTIVE(HA[g]), .H_FP(HF[g]), .H_SYNC(HS[g]), .H_BP(HB[g]),
      .V_ACTIVE(VA[g]), .V_FP(VF[g]), .V_SYNC(VS[g]), .V_BP(VB[g]),
      .H_POL(HP[g]), .V_POL(VP[g]), .PIPE_DLY(DL[g]), .COORD_W(14)
    ) dut (
      .clk          (clk),
      .reset        (reset),
      .i_enable     (i_enable),
      .o_x          (ox[g]),
      .o_y          (oy[g]),
      .o_hvesync    (hv[g]),
      .o_line_start (ls[g]),
      .o_frame_start(fs[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int h_total(int k);
    return HA[k] + HF[k] + HS[k] + HB[k];
  endfunction

  function automatic int v_total(int k);
    return VA[k] + VF[k] + VS[k] + VB[k];
  endfunction

  function automatic logic [4:0] inactive(int k);
    return {~HP[k], ~VP[k], 3'b000};
  endfunction

  function automatic logic [4:0] ref_raw(int k, int x, int y);
    logic h, v, d;
    d = (x < HA[k]) && (y < VA[k]);
    h = (x >= HA[k] + HF[k] && x < HA[k] + HF[k] + HS[k]) ? HP[k] : ~HP[k];
    v = (y >= VA[k] + VF[k] && y < VA[k] + VF[k] + VS[k]) ? VP[k] : ~VP[k];
    return {h, v, d, x == 0, (x == 0) && (y == 0)};
  endfunction

  task automatic check(string tag, int k, logic [13:0] got, logic [13:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, k, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic e);
    int         px, py;
    logic [4:0] raw, exp_w;
    int         ex [N];
    int         ey [N];
    logic [4:0] ew [N];
    @(negedge clk);
    reset    = r;
    i_enable = e;
    @(posedge clk);
    for (int k = 0; k < N; k++) begin
      if (r)             begin t[k] = 0; running[k] = e; end
      else if (!e)       begin t[k] = 0; running[k] = 1'b0; end
      else if (!running[k]) begin t[k] = 0; running[k] = 1'b1; end
      else t[k] = (t[k] + 1) % (h_total(k) * v_total(k));
      px = t[k] % h_total(k);
      py = t[k] / h_total(k);
      raw = running[k] ? ref_raw(k, px, py) : inactive(k);
      if (r) for (int j = 0; j < 16; j++) hist[k][j] = inactive(k);
      for (int j = 15; j > 0; j--) hist[k][j] = hist[k][j-1];
      hist[k][0] = raw;
      exp_w = r ? inactive(k) : hist[k][DL[k]];
      ex[k] = px;
      ey[k] = py;
      ew[k] = exp_w;
    end
    #1;
    for (int k = 0; k < N; k++) begin
      check("x",   k, ox[k], 14'(ex[k]));
      check("y",   k, oy[k], 14'(ey[k]));
      check("hve", k, 14'(hv[k]), 14'(ew[k][4:2]));
      check("ls",  k, 14'(ls[k]), 14'(ew[k][1]));
      check("fs",  k, 14'(fs[k]), 14'(ew[k][0]));
    end
  endtask

  initial begin
    int len;
    reset    = 1'b1;
    i_enable = 1'b1;
    for (int k = 0; k < N; k++) begin
      t[k] = 0;
      running[k] = 1'b0;
      for (int j = 0; j < 16; j++) hist[k][j] = inactive(k);
    end

    // Reset, then release with enable high and run two full frames of the largest raster.
    repeat (3) step(1'b1, 1'b1);
    repeat (2 * 275 + 10) step(1'b0, 1'b1);

    // Mid-frame disables of random length at random points.
    repeat (8) begin
      len = $urandom_range(1, 300);
      repeat (len) step(1'b0, 1'b1);
      len = $urandom_range(1, 6);
      repeat (len) step(1'b0, 1'b0);
    end

    // Single-cycle resets mid-frame, including reset together with enable low.
    repeat (6) begin
      len = $urandom_range(5, 250);
      repeat (len) step(1'b0, 1'b1);
      step(1'b1, 1'($urandom_range(0, 1)));
    end
    step(1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0);

    // Random mix of enable drops and occasional reset.
    repeat (2000) step(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 29) != 0));

    repeat (600) step(1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
